// File: rtl/adder_serial_n.sv
// Digit-serial N-bit adder/subtractor: one W-bit slice per clock, LSB first,
// with the carry held in a register between slices.
module adder_serial_n #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sub,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] s,
   output logic         cout,
   output logic         ovf,
   output logic [1:0]   dbg_state_o
);

   localparam int M  = N / W;
   localparam int KW = (M > 1) ? $clog2(M) : 1;
   localparam int WP = W + 1;

   // Handshake: start is a request taken only on an edge where busy=0; there
   // is no ready, so a start seen while busy is dropped, not queued. Every
   // accepted request yields exactly one done pulse unless reset intervenes.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic          carry_q, carry_d;
   logic [N-1:0]  opa_q, opa_d;
   logic [N-1:0]  opb_q, opb_d;
   logic [N-1:0]  res_q, res_d;
   logic [N-1:0]  s_q, s_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [W:0]    slice_sum;
   int            base;

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      carry_d   = carry_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      res_d     = res_q;
      s_d       = s_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
      slice_sum = '0;
      base      = int'(k_q) * W;
      case (state_q)
         IDLE: begin
            if (start) begin
               opa_d   = a;
               opb_d   = sub ? ~b : b;
               carry_d = sub;
               k_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            slice_sum = {1'b0, opa_q[base +: W]} + {1'b0, opb_q[base +: W]} + WP'(carry_q);
            res_d[base +: W] = slice_sum[W-1:0];
            carry_d = slice_sum[W];
            k_d     = k_q + KW'(1);
            // Visible outputs are loaded only once the whole word is known.
            if (k_q == KW'(M - 1)) begin
               state_d = DONE;
               k_d     = '0;
               s_d     = res_d;
               cout_d  = slice_sum[W];
               ovf_d   = (opa_q[N-1] == opb_q[N-1]) && (res_d[N-1] != opa_q[N-1]);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         carry_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign s           = s_q;
   assign cout        = cout_q;
   assign ovf         = ovf_q;
   assign dbg_state_o = state_q;

endmodule
